// File: rtl/spi_pkg.sv
// spi_pkg: FSM states, sample-edge selection and default synchronizer depth for spi_slave_mb
package spi_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;
    localparam int SPI_SYNC_DEFAULT = 2;
    function automatic logic sample_rising(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: N-flop pin synchronizer with registered rise/fall detect, quiet until the chain refills after reset
module spi_pin_sync #(
    parameter int STAGES = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic [STAGES:0] warm;
    logic prev;
    assign q = chain[STAGES-1];
    // warm keeps a pin held at a non-reset level from looking like an edge once reset releases
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            warm  <= '0;
            prev  <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            warm  <= {warm[STAGES-1:0], 1'b1};
            prev  <= q;
            rise  <= warm[STAGES] & q & ~prev;
            fall  <= warm[STAGES] & ~q & prev;
        end
    end
endmodule

// File: rtl/spi_slave_mb.sv
// spi_slave_mb: oversampled multi-byte full-duplex SPI slave, any mode; SPI_SLAVE_DEBUG_EN adds the dbg port
module spi_slave_mb
    import spi_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0,
    parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
    input  logic                    sysClk,
    input  logic                    reset,
    input  logic                    spiClk,
    input  logic                    mosi,
    input  logic                    cs,
    output logic                    miso,
    input  logic [8*DATA_BYTES-1:0] tx_data,
    input  logic                    tx_load,
    output logic [7:0]              rx_byte,
    output logic                    byte_valid,
    output logic [8*DATA_BYTES-1:0] rx_data,
    output logic                    rx_valid,
    output logic                    frame_active,
    output logic                    frame_error
`ifdef SPI_SLAVE_DEBUG_EN
    ,
    output logic [15:0]             dbg
`endif
);
    localparam int FW = 8 * DATA_BYTES;
    localparam int CW = $clog2(FW);
    localparam logic SAMPLE_RISE = sample_rising(CPOL, CPHA);

    logic sclk_q, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic cs_q, cs_rise, cs_fall;
    logic sample, shift, last, first;
    logic unused_pins;
    state_t state;
    logic [CW-1:0] cnt;
    logic [FW-1:0] tx_sr, tx_shadow, rx_sr, reload;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk (
        .clk(sysClk), .rst(reset), .pin(spiClk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(sysClk), .rst(reset), .pin(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(sysClk), .rst(reset), .pin(cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall));

    assign unused_pins  = ^{sclk_q, mosi_rise, mosi_fall, cs_q};
    assign sample       = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift        = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign last         = cnt == CW'(FW - 1);
    assign reload       = tx_load ? tx_data : tx_shadow;
    assign frame_active = state != IDLE;

    // first: the next shift edge presents a freshly loaded MSB instead of shifting
    always_ff @(posedge sysClk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            tx_shadow   <= '0;
            first       <= 1'b0;
            miso        <= 1'b0;
            rx_byte     <= '0;
            rx_data     <= '0;
            byte_valid  <= 1'b0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            if (tx_load) tx_shadow <= tx_data;
            if (cs_rise) begin
                state       <= IDLE;
                frame_error <= (state != IDLE) && (cnt != '0);
                cnt         <= '0;
                miso        <= 1'b0;
            end else if (state == IDLE) begin
                miso <= 1'b0;
                if (cs_fall) begin
                    state <= ARMED;
                    cnt   <= '0;
                    tx_sr <= reload;
                    first <= CPHA;
                    miso  <= CPHA ? 1'b0 : reload[FW-1];
                end
            end else if (sample) begin
                state <= SHIFT;
                rx_sr <= {rx_sr[FW-2:0], mosi_q};
                cnt   <= last ? '0 : cnt + 1'b1;
                if (cnt[2:0] == 3'd7) begin
                    rx_byte    <= {rx_sr[6:0], mosi_q};
                    byte_valid <= 1'b1;
                end
                if (last) begin
                    rx_data  <= {rx_sr[FW-2:0], mosi_q};
                    rx_valid <= 1'b1;
                    tx_sr    <= reload;
                    first    <= 1'b1;
                end
            end else if (shift) begin
                first <= 1'b0;
                if (first) begin
                    miso <= tx_sr[FW-1];
                end else begin
                    tx_sr <= tx_sr << 1;
                    miso  <= tx_sr[FW-2];
                end
            end
        end
    end

`ifdef SPI_SLAVE_DEBUG_EN
    always_ff @(posedge sysClk) begin
        if (reset) dbg <= '0;
        else dbg <= {3'(state), 5'(cnt), sclk_q, mosi_q, cs_q, sclk_rise, sclk_fall,
                     byte_valid, rx_valid, frame_error};
    end
`endif
endmodule

// File: tb/tb_spi_slave_mb.sv
// tb_spi_slave_mb: scoreboard bench for spi_slave_mb in all four modes plus a 1-byte, 3-stage instance
module tb_spi_slave_mb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, sclk, mosi, tx_load;
    logic [4:0] cs;
    logic [31:0] tx_data;
    logic [2:0] sel;
    logic [7:0] rb4 [4];
    logic [31:0] rd4 [4];
    logic bv4 [4], rv4 [4], fa4 [4], fe4 [4], miso4 [4];
    logic [7:0] rb1, rd1;
    logic bv1, rv1, fa1, fe1, miso1;
`ifdef SPI_SLAVE_DEBUG_EN
    logic [15:0] dbg4 [4];
    logic [15:0] dbg1;
`endif

    for (genvar m = 0; m < 4; m++) begin : g_mode
        spi_slave_mb #(.DATA_BYTES(4), .CPOL(1'(m / 2)), .CPHA(1'(m % 2))) u_dut (
            .sysClk(clk), .reset(reset), .spiClk(sclk), .mosi(mosi), .cs(cs[m]), .miso(miso4[m]),
            .tx_data(tx_data), .tx_load(tx_load), .rx_byte(rb4[m]), .byte_valid(bv4[m]),
            .rx_data(rd4[m]), .rx_valid(rv4[m]), .frame_active(fa4[m]), .frame_error(fe4[m])
`ifdef SPI_SLAVE_DEBUG_EN
            , .dbg(dbg4[m])
`endif
        );
    end

    spi_slave_mb #(.DATA_BYTES(1), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(3)) u_dut1 (
        .sysClk(clk), .reset(reset), .spiClk(sclk), .mosi(mosi), .cs(cs[4]), .miso(miso1),
        .tx_data(tx_data[7:0]), .tx_load(tx_load), .rx_byte(rb1), .byte_valid(bv1),
        .rx_data(rd1), .rx_valid(rv1), .frame_active(fa1), .frame_error(fe1)
`ifdef SPI_SLAVE_DEBUG_EN
        , .dbg(dbg1)
`endif
    );

    logic [7:0] rb_s;
    logic [63:0] rd_s;
    logic bv_s, rv_s, fa_s, fe_s, miso_s;
    always_comb begin
        rb_s   = sel == 3'd4 ? rb1 : rb4[sel[1:0]];
        rd_s   = sel == 3'd4 ? 64'(rd1) : 64'(rd4[sel[1:0]]);
        bv_s   = sel == 3'd4 ? bv1 : bv4[sel[1:0]];
        rv_s   = sel == 3'd4 ? rv1 : rv4[sel[1:0]];
        fa_s   = sel == 3'd4 ? fa1 : fa4[sel[1:0]];
        fe_s   = sel == 3'd4 ? fe1 : fe4[sel[1:0]];
        miso_s = sel == 3'd4 ? miso1 : miso4[sel[1:0]];
    end

    int n_checks = 0, n_errors = 0, n_rv = 0, n_fe = 0;
    logic [7:0] exp_b [$];
    logic [63:0] exp_f [$];
    logic [63:0] e_b, e_f;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bv_s) begin
                e_b = 'x;
                if (exp_b.size() > 0) e_b = 64'(exp_b.pop_front());
                check("rx_byte", 64'(rb_s), e_b);
                if (sel == 3'd4) check("bv_with_rv", 64'(rv_s), 64'd1);
            end
            if (rv_s) begin
                n_rv++;
                e_f = 'x;
                if (exp_f.size() > 0) e_f = exp_f.pop_front();
                check("rx_data", rd_s, e_f);
                check("rv_with_bv", 64'(bv_s), 64'd1);
            end
            if (fe_s) n_fe++;
        end
    end

    task automatic load(input logic [31:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic xfer(input int nbits, input logic [63:0] tx, input int half, output logic [63:0] rx);
        logic cpol, cpha;
        cpol = sel < 3'd4 ? sel[1] : 1'b0;
        cpha = sel < 3'd4 ? sel[0] : 1'b0;
        rx = '0;
        sclk = cpol;
        mosi = cpha ? 1'b0 : tx[nbits-1];
        #(2 * half);
        cs[sel] = 1'b0;
        #(2 * half);
        for (int i = 0; i < nbits; i++) begin
            if (cpha) mosi = tx[nbits-1-i];
            else rx = {rx[62:0], miso_s};
            sclk = ~cpol;
            #(half);
            if (cpha) rx = {rx[62:0], miso_s};
            else mosi = (i + 1 < nbits) ? tx[nbits-2-i] : 1'b0;
            sclk = cpol;
            #(half);
        end
        cs[sel] = 1'b1;
        #200;
    endtask

    task automatic send(input int nbits, input int fw, input logic [63:0] tx, input int half,
                        output logic [63:0] rx);
        for (int k = 0; k < nbits / 8; k++) exp_b.push_back(8'(tx >> (nbits - 8 * (k + 1))));
        for (int k = 0; k < nbits / fw; k++)
            exp_f.push_back((tx >> (nbits - fw * (k + 1))) & ((64'd1 << fw) - 64'd1));
        xfer(nbits, tx, half, rx);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rx;
        int rv0, fe0;
        cs = '1; sclk = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = '0; sel = '0; reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_rx_data", rd_s, 64'd0);
        check("rst_rx_byte", 64'(rb_s), 64'd0);
        check("rst_miso", 64'(miso_s), 64'd0);
        check("rst_active", 64'(fa_s), 64'd0);
        check("rst_strobes", 64'({bv_s, rv_s, fe_s}), 64'd0);
        check("rst_rx_data1", 64'(rd1), 64'd0);

        for (int m = 0; m < 4; m++) begin
            sel = 3'(m);
            load(32'hCAFEF00D);
            send(32, 32, 64'hDEADBEEF, 50, rx);
            check("mode_miso", rx, 64'hCAFEF00D);
            check("mode_rx_data", rd_s, 64'hDEADBEEF);
            check("mode_drain", 64'(exp_b.size() + exp_f.size()), 64'd0);
        end

        sel = 3'd0;
        fe0 = n_fe;
        rv0 = n_rv;
        send(12, 32, 64'hDEA, 50, rx);
        check("abort_err", 64'(n_fe - fe0), 64'd1);
        check("abort_rv", 64'(n_rv - rv0), 64'd0);
        check("abort_hold", rd_s, 64'hDEADBEEF);
        check("abort_idle", 64'(fa_s), 64'd0);
        check("abort_drain", 64'(exp_b.size() + exp_f.size()), 64'd0);

        load(32'hCAFEF00D);
        rv0 = n_rv;
        fork
            send(64, 32, 64'h01020304_A5A55A5A, 50, rx);
            begin
                #1200;
                load(32'h11223344);
            end
        join
        check("b2b_rv", 64'(n_rv - rv0), 64'd2);
        check("b2b_miso0", 64'(rx[63:32]), 64'hCAFEF00D);
        check("b2b_miso1", 64'(rx[31:0]), 64'h11223344);
        check("b2b_rx_data", rd_s, 64'hA5A55A5A);
        check("b2b_drain", 64'(exp_b.size() + exp_f.size()), 64'd0);

        fe0 = n_fe;
        fork
            xfer(32, 64'hFFFFFFFF, 50, rx);
            begin
                #750;
                @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        check("rst_mid_rx_data", rd_s, 64'd0);
        send(32, 32, 64'h12345678, 50, rx);
        check("rst_mid_no_err", 64'(n_fe - fe0), 64'd0);
        check("rst_mid_frame", rd_s, 64'h12345678);
        check("rst_mid_miso", rx, 64'd0);
        check("rst_mid_drain", 64'(exp_b.size() + exp_f.size()), 64'd0);

        sel = 3'd4;
        rv0 = n_rv;
        send(32, 8, 64'hA1B2C3D4, 40, rx);
        check("db1_frames", 64'(n_rv - rv0), 64'd4);
        check("db1_last", rd_s, 64'hD4);
        check("db1_drain", 64'(exp_b.size() + exp_f.size()), 64'd0);
        check("miso_idle", 64'(miso_s), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
